debounce_array: RTL and testbench



---
 rtl/debounce_pkg.sv | 19 +
 rtl/debounce_array_if.sv | 22 ++
 rtl/debounce_channel.sv | 99 +++++++++
 rtl/debounce_array.sv | 68 ++++++
 tb/tb_debounce_array.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared widths, limits and POR state encoding for debounce_array.
package debounce_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic {
        POR_HOLD,
        POR_DONE
    } por_state_e;

    function automatic int CNT_W(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

    function automatic int LONG_W(input int long_ticks);
        return $clog2(long_ticks + 1);
    endfunction

endpackage

// File: rtl/debounce_array_if.sv
// debounce_array_if: raw button/tick inputs and conditioned outputs of debounce_array.
interface debounce_array_if #(
    parameter int N_CH = 3
);
    logic            tick_1kHz;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_rise;
    logic [N_CH-1:0] btn_fall;
    logic [N_CH-1:0] btn_long;
    logic            sys_reset_out;

    modport master (
        output tick_1kHz, btn_in,
        input  btn_level, btn_rise, btn_fall, btn_long, sys_reset_out
    );

    modport slave (
        input  tick_1kHz, btn_in,
        output btn_level, btn_rise, btn_fall, btn_long, sys_reset_out
    );
endinterface

// File: rtl/debounce_channel.sv
// debounce_channel: synchroniser, tick-qualified stability filter and edge pulses for one button.
// Optional long-press hold counter is built only with DEBOUNCE_LONG_PRESS_EN.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 8,
    parameter int LONG_TICKS   = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic long_o
);
    localparam int CW = CNT_W(STABLE_TICKS);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          sync;

    assign sync = sync_q[1];

    // Any tick that sees the current level again restarts the stability count.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (tick_i) begin
            if (sync == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(STABLE_TICKS - 1)) begin
                cnt_d   = '0;
                level_d = sync;
                rise_d  = sync;
                fall_d  = !sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int LW = LONG_W(LONG_TICKS);

    logic [LW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Saturating at LONG_TICKS suppresses repeats until the level drops.
    always_comb begin
        hold_d = !level_q ? '0 : (tick_i && hold_q != LW'(LONG_TICKS)) ? hold_q + 1'b1 : hold_q;
        long_d = level_q && tick_i && hold_q == LW'(LONG_TICKS - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

    if (STABLE_TICKS < 1 || LONG_TICKS < 1) begin : g_bad_cfg
        $error("debounce_channel: STABLE_TICKS and LONG_TICKS must be >= 1");
    end
endmodule

// File: rtl/debounce_array.sv
// debounce_array: N-channel push-button conditioner plus power-on system reset request.
// Define DEBOUNCE_LONG_PRESS_EN to enable per-channel long-press pulses on btn_long.
module debounce_array
    import debounce_pkg::*;
#(
    parameter int N_CH         = 3,
    parameter int STABLE_TICKS = 8,
    parameter int POR_CYCLES   = 8,
    parameter int RESET_CH     = 0,
    parameter int LONG_TICKS   = 1000
) (
    input logic              clk_100MHz,
    input logic              reset_n,
    debounce_array_if.slave  bus
);
    localparam int PW = $clog2(POR_CYCLES + 1);

    logic [N_CH-1:0] level, rise, fall, lng;
    por_state_e      por_state_q, por_state_d;
    logic [PW-1:0]   por_cnt_q, por_cnt_d;
    logic            por_active;

    if (N_CH < 1 || N_CH > MAX_CH || RESET_CH < 0 || RESET_CH >= N_CH || POR_CYCLES < 1) begin : g_bad_cfg
        $error("debounce_array: invalid channel or POR configuration");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS)
        ) u_ch (
            .clk     (clk_100MHz),
            .rst_n   (reset_n),
            .tick_i  (bus.tick_1kHz),
            .btn_i   (bus.btn_in[i]),
            .level_o (level[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i]),
            .long_o  (lng[i])
        );
    end

    assign bus.btn_level = level;
    assign bus.btn_rise  = rise;
    assign bus.btn_fall  = fall;
    assign bus.btn_long  = lng;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            por_state_q <= POR_HOLD;
            por_cnt_q   <= '0;
        end else begin
            por_state_q <= por_state_d;
            por_cnt_q   <= por_cnt_d;
        end
    end

    always_comb begin
        por_state_d = (por_state_q == POR_HOLD && por_cnt_q == PW'(POR_CYCLES - 1)) ? POR_DONE : por_state_q;
        por_cnt_d   = (por_state_q == POR_HOLD) ? por_cnt_q + 1'b1 : por_cnt_q;
    end

    // The reset button only contributes its accepted-press pulse, not its level.
    always_comb begin
        por_active        = (por_state_q == POR_HOLD);
        bus.sys_reset_out = por_active | rise[RESET_CH];
    end
endmodule

// File: tb/tb_debounce_array.sv
// tb_debounce_array: randomized and directed scoreboard bench for debounce_array.
module tb_debounce_array;
    localparam int N   = 3;
    localparam int ST  = 8;
    localparam int POR = 8;
    localparam int RCH = 0;
    localparam int LT  = 20;
    localparam int P   = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    debounce_array_if #(.N_CH(N)) bus ();

    debounce_array #(
        .N_CH         (N),
        .STABLE_TICKS (ST),
        .POR_CYCLES   (POR),
        .RESET_CH     (RCH),
        .LONG_TICKS   (LT)
    ) dut (
        .clk_100MHz (clk),
        .reset_n    (reset_n),
        .bus        (bus)
    );

    typedef struct {
        int           cyc;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] lng;
        logic [N-1:0] lvl;
        logic         sys;
    } ev_t;

    ev_t          exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [N-1:0] m_lvl;
    logic [N-1:0] dly[$];
    bit           m_hist[N][$];
    int           m_hold[N];
    int           m_k;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        dly.delete();
        dly.push_back('0);
        dly.push_back('0);
        m_lvl = '0;
        for (int ch = 0; ch < N; ch++) begin
            m_hist[ch].delete();
            m_hold[ch] = 0;
        end
        m_k = 0;
        exp_q.delete();
    endtask

    // A level flips when the last ST tick samples all disagree with it.
    task automatic model_step(input logic [N-1:0] b, input logic t);
        logic [N-1:0] sv, old, r, f, l;
        bit           all_opp;
        ev_t          e;
        sv = dly.pop_front();
        dly.push_back(b);
        m_k++;
        old = m_lvl;
        r = '0;
        f = '0;
        l = '0;
        for (int ch = 0; ch < N; ch++) begin
            if (t) begin
                m_hist[ch].push_back(sv[ch]);
                if (m_hist[ch].size() > ST) void'(m_hist[ch].pop_front());
                all_opp = (m_hist[ch].size() == ST);
                for (int j = 0; j < m_hist[ch].size(); j++)
                    if (m_hist[ch][j] == old[ch]) all_opp = 0;
                if (all_opp) begin
                    m_lvl[ch] = !old[ch];
                    r[ch] = !old[ch];
                    f[ch] = old[ch];
                end
            end
`ifdef DEBOUNCE_LONG_PRESS_EN
            if (!old[ch]) m_hold[ch] = 0;
            else if (t && m_hold[ch] < LT) begin
                m_hold[ch]++;
                l[ch] = (m_hold[ch] == LT);
            end
`endif
        end
        e.cyc  = m_k;
        e.rise = r;
        e.fall = f;
        e.lng  = l;
        e.lvl  = m_lvl;
        e.sys  = (m_k < POR) || r[RCH];
        if (e.sys || (r | f | l) != '0) exp_q.push_back(e);
    endtask

    task automatic step(input logic [N-1:0] b, input logic t);
        @(negedge clk);
        #1;
        bus.btn_in    = b;
        bus.tick_1kHz = t;
        model_step(b, t);
    endtask

    task automatic ticks(input logic [N-1:0] b, input int n);
        repeat (n) begin
            repeat (P - 1) step(b, 1'b0);
            step(b, 1'b1);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_level"}, 32'(bus.btn_level), 0);
        chk({tag, "_rise"}, 32'(bus.btn_rise), 0);
        chk({tag, "_fall"}, 32'(bus.btn_fall), 0);
        chk({tag, "_long"}, 32'(bus.btn_long), 0);
        chk({tag, "_sys"}, 32'(bus.sys_reset_out), 1);
    endtask

    task automatic release_rst();
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        bus.tick_1kHz = 1'b0;
        #1;
        chk("por_at_release", 32'(bus.sys_reset_out), 1);
        model_step(bus.btn_in, 1'b0);
    endtask

    always @(negedge clk) begin : mon
        ev_t  e;
        logic dut_ev;
        if (reset_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event: cyc=%0d expected rise=%b fall=%b long=%b sys=%b not seen", e.cyc, e.rise, e.fall, e.lng, e.sys);
            end
            dut_ev = (|bus.btn_rise) | (|bus.btn_fall) | (|bus.btn_long) | bus.sys_reset_out;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if ({bus.btn_rise, bus.btn_fall, bus.btn_long, bus.btn_level, bus.sys_reset_out} !==
                    {e.rise, e.fall, e.lng, e.lvl, e.sys}) begin
                    errors++;
                    $display("FAIL event cyc=%0d: got rise=%b fall=%b long=%b level=%b sys=%b expected rise=%b fall=%b long=%b level=%b sys=%b",
                             cyc, bus.btn_rise, bus.btn_fall, bus.btn_long, bus.btn_level, bus.sys_reset_out,
                             e.rise, e.fall, e.lng, e.lvl, e.sys);
                end
            end else if (dut_ev) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event cyc=%0d: got rise=%b fall=%b long=%b sys=%b expected no pulse",
                         cyc, bus.btn_rise, bus.btn_fall, bus.btn_long, bus.sys_reset_out);
            end
        end
    end

    initial begin
        logic [N-1:0] rb;
        bus.btn_in    = '0;
        bus.tick_1kHz = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset");
        release_rst();
        repeat (12) step('0, 1'b0);
        ticks(3'b010, 12);
        ticks(3'b000, 12);
        ticks(3'b010, ST - 1);
        ticks(3'b000, 12);
        ticks(3'b100, 5);
        ticks(3'b000, 1);
        ticks(3'b100, 12);
        ticks(3'b000, 12);
        ticks(3'b110, 12);
        ticks(3'b000, 12);
        ticks(3'b001, 12);
        ticks(3'b000, 12);
        ticks(3'b001, 40);
        ticks(3'b000, 12);
        ticks(3'b010, 5);
        @(negedge clk);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_values("midreset");
        repeat (3) @(negedge clk);
        release_rst();
        ticks(3'b010, 12);
        ticks(3'b000, 12);
        rb = '0;
        repeat (3000) begin
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(0, 23) == 0) rb[ch] = !rb[ch];
            step(rb, $urandom_range(0, 2) == 0);
        end
        ticks(3'b000, 12);
        repeat (20) step('0, 1'b0);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
